// File: rtl/dmg_bus_pkg.sv
// Shared types and constants for the CPU bus cycle sequencer.
package dmg_bus_pkg;

    localparam int unsigned BUS_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        T3,
        T4
    } bus_tstate_t;

    typedef enum logic {
        CYC_RD,
        CYC_WR
    } bus_cyc_t;

endpackage

// File: rtl/bus_tstate_fsm.sv
// T-state sequencer: IDLE -> T1..T4, write-priority request acceptance in IDLE and T4.
// Optional macro BUS_WAIT_EN lets the wait input stretch T3.
module bus_tstate_fsm
    import dmg_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic        wait_req,
    output bus_tstate_t state,
    output bus_tstate_t next_state,
    output bus_cyc_t    cyc,
    output bus_cyc_t    next_cyc,
    output logic        accept
);

    logic take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cyc   <= CYC_RD;
        end else begin
            state <= next_state;
            cyc   <= next_cyc;
        end
    end

    always_comb begin
        next_state = state;
        next_cyc   = cyc;
        take       = 1'b0;
        unique case (state)
            IDLE, T4: begin
                if (wr_req) begin
                    take       = 1'b1;
                    next_cyc   = CYC_WR;
                    next_state = T1;
                end else if (rd_req) begin
                    take       = 1'b1;
                    next_cyc   = CYC_RD;
                    next_state = T1;
                end else begin
                    next_state = IDLE;
                end
            end
            T1: next_state = T2;
            T2: next_state = T3;
            T3: begin
`ifdef BUS_WAIT_EN
                next_state = wait_req ? T3 : T4;
`else
                next_state = T4;
`endif
            end
            default: next_state = IDLE;
        endcase
    end

    // Gated so no accept is reported while the sequencer is held in reset.
    assign accept = take & rst_n;

`ifndef BUS_WAIT_EN
    logic unused_wait;
    assign unused_wait = wait_req;
`endif

endmodule

// File: rtl/bus_cycle_sequencer.sv
// CPU memory M-cycle sequencer feeding the DV->DL data bridge; captures read data from DL.
// Optional macro BUS_WAIT_EN enables WAIT-driven T3 stretching.
module bus_cycle_sequencer
    import dmg_bus_pkg::*;
#(
    parameter int unsigned DATA_W     = BUS_DATA_W,
    parameter bit          WR_HOLD_T4 = 1'b1
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              RD_REQ,
    input  logic              WR_REQ,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [DATA_W-1:0] DL,
    input  logic              WAIT,
    output logic              ACCEPT,
    output logic [DATA_W-1:0] DV,
    output logic              DataOut,
    output logic              nRD,
    output logic              nWR,
    output logic [DATA_W-1:0] RDATA,
    output logic              RD_VALID,
    output logic              BUSY
);

    bus_tstate_t state;
    bus_tstate_t next_state;
    bus_cyc_t    cyc;
    bus_cyc_t    next_cyc;
    logic        accept;

    logic busy_d;
    logic dout_d;
    logic nrd_d;
    logic nwr_d;
    logic capture;
    logic load_dv;

    bus_tstate_fsm u_fsm (
        .clk        (CLK),
        .rst_n      (nRESET),
        .rd_req     (RD_REQ),
        .wr_req     (WR_REQ),
        .wait_req   (WAIT),
        .state      (state),
        .next_state (next_state),
        .cyc        (cyc),
        .next_cyc   (next_cyc),
        .accept     (accept)
    );

    assign ACCEPT = accept;

    // Outputs are registered from the next state so they line up with the T-state they belong to.
    always_comb begin
        busy_d  = (next_state != IDLE);
        dout_d  = 1'b0;
        nwr_d   = 1'b1;
        nrd_d   = 1'b1;
        if (next_cyc == CYC_WR) begin
            dout_d = (next_state == T2) || (next_state == T3) ||
                     (WR_HOLD_T4 && (next_state == T4));
            nwr_d  = !((next_state == T2) || (next_state == T3));
        end else begin
            nrd_d  = !((next_state == T1) || (next_state == T2) || (next_state == T3));
        end
        capture = (cyc == CYC_RD) && (state == T3) && (next_state == T4);
        load_dv = accept && (next_cyc == CYC_WR);
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            DV       <= '0;
            DataOut  <= 1'b0;
            nRD      <= 1'b1;
            nWR      <= 1'b1;
            RDATA    <= '0;
            RD_VALID <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            if (load_dv) begin
                DV <= WDATA;
            end
            if (capture) begin
                RDATA <= DL;
            end
            DataOut  <= dout_d;
            nRD      <= nrd_d;
            nWR      <= nwr_d;
            RD_VALID <= capture;
            BUSY     <= busy_d;
        end
    end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Randomized scoreboard bench for bus_cycle_sequencer: a transaction-level plan yields
// per-cycle expected outputs plus write/read data queues checked by an independent monitor.
module tb_bus_cycle_sequencer;

    localparam int NCYC = 2000;
    localparam bit HOLD = 1'b1;

    logic       CLK = 1'b0;
    logic       nRESET;
    logic       RD_REQ;
    logic       WR_REQ;
    logic [7:0] WDATA;
    logic [7:0] DL;
    logic       WAIT;
    logic       ACCEPT;
    logic [7:0] DV;
    logic       DataOut;
    logic       nRD;
    logic       nWR;
    logic [7:0] RDATA;
    logic       RD_VALID;
    logic       BUSY;

    always #5 CLK = ~CLK;

    bus_cycle_sequencer #(
        .DATA_W     (8),
        .WR_HOLD_T4 (HOLD)
    ) dut (
        .CLK      (CLK),
        .nRESET   (nRESET),
        .RD_REQ   (RD_REQ),
        .WR_REQ   (WR_REQ),
        .WDATA    (WDATA),
        .DL       (DL),
        .WAIT     (WAIT),
        .ACCEPT   (ACCEPT),
        .DV       (DV),
        .DataOut  (DataOut),
        .nRD      (nRD),
        .nWR      (nWR),
        .RDATA    (RDATA),
        .RD_VALID (RD_VALID),
        .BUSY     (BUSY)
    );

    // Stimulus plan, one entry per clock cycle.
    bit         d_rst [NCYC];
    bit         d_wr  [NCYC];
    bit         d_rd  [NCYC];
    bit         d_wait[NCYC];
    logic [7:0] d_wdata[NCYC];
    logic [7:0] d_dl  [NCYC];

    // Expected outputs, one entry per clock cycle.
    bit         e_acc [NCYC];
    bit         e_busy[NCYC];
    bit         e_dout[NCYC];
    bit         e_nrd [NCYC];
    bit         e_nwr [NCYC];
    bit         e_rdv [NCYC];
    logic [7:0] e_dv  [NCYC];
    logic [7:0] e_rdata[NCYC];

    logic [7:0] wr_q[$];
    logic [7:0] rd_q[$];

    int n_chk   = 0;
    int n_fail  = 0;
    int end_cyc = NCYC;

    task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, k, act, exp);
        end
    endtask

    // One M-cycle accepted at cycle a, with w extra T3 wait cycles; lasts 4+w cycles after a.
    task automatic sched(bit is_wr, int a, int w, logic [7:0] data);
        int len;
        len = 4 + w;
        e_acc[a] = 1'b1;
        for (int k = a + 1; k <= a + len; k++) e_busy[k] = 1'b1;
        if (is_wr) begin
            d_wdata[a] = data;
            for (int k = a + 1; k < NCYC; k++) e_dv[k] = data;
            for (int k = a + 2; k <= a + 3 + w; k++) begin
                e_dout[k] = 1'b1;
                e_nwr[k]  = 1'b0;
            end
            if (HOLD) e_dout[a + len] = 1'b1;
            wr_q.push_back(data);
        end else begin
            for (int k = a + 1; k <= a + 3 + w; k++) e_nrd[k] = 1'b0;
            e_rdv[a + len] = 1'b1;
            for (int k = a + len; k < NCYC; k++) e_rdata[k] = data;
            // DL only carries the real value in the last T3 cycle; elsewhere it is noise.
            d_dl[a + 3 + w] = data;
            rd_q.push_back(data);
        end
`ifdef BUS_WAIT_EN
        for (int k = a + 3; k < a + 3 + w; k++) d_wait[k] = 1'b1;
        d_wait[a + 3 + w] = 1'b0;
`endif
    endtask

    function automatic int pick_wait();
`ifdef BUS_WAIT_EN
        return int'($urandom_range(0, 3));
`else
        return 0;
`endif
    endfunction

    // Plan generation and driver.
    initial begin
        int free, prev_a, i, a, ar, w, w2, kind, r;
        logic [7:0] data, data2;

        for (int k = 0; k < NCYC; k++) begin
            d_rst[k]   = 1'b0;
            d_wr[k]    = 1'b0;
            d_rd[k]    = 1'b0;
            d_wdata[k] = 8'($urandom);
            d_dl[k]    = 8'($urandom);
`ifdef BUS_WAIT_EN
            d_wait[k]  = 1'b0;
`else
            d_wait[k]  = 1'($urandom);
`endif
            e_acc[k]   = 1'b0;
            e_busy[k]  = 1'b0;
            e_dout[k]  = 1'b0;
            e_nrd[k]   = 1'b1;
            e_nwr[k]   = 1'b1;
            e_rdv[k]   = 1'b0;
            e_dv[k]    = 8'h00;
            e_rdata[k] = 8'h00;
        end
        d_rst[0] = 1'b1;
        d_rst[1] = 1'b1;

        // Cycles 2..11 stay idle; the bus can first accept at cycle 12.
        free   = 12;
        prev_a = 11;
        for (int n = 0; n < 80; n++) begin
            if (free > NCYC - 100) break;
            kind = int'($urandom_range(0, 2));
            w    = pick_wait();
            w2   = pick_wait();
            data = 8'($urandom);
            i    = free + int'($urandom_range(0, 3)) - int'($urandom_range(0, 3));
            if (i < prev_a + 1) i = prev_a + 1;
            a    = (i > free) ? i : free;
            if (kind == 1) begin
                for (int k = i; k <= a; k++) d_rd[k] = 1'b1;
                sched(1'b0, a, w, data);
                prev_a = a;
                free   = a + 4 + w;
            end else begin
                for (int k = i; k <= a; k++) begin
                    d_wr[k]    = 1'b1;
                    d_wdata[k] = data;
                end
                sched(1'b1, a, w, data);
                prev_a = a;
                free   = a + 4 + w;
                if (kind == 2) begin
                    // Read held alongside the write is taken in the write's T4.
                    ar    = a + 4 + w;
                    data2 = 8'($urandom);
                    for (int k = i; k <= ar; k++) d_rd[k] = 1'b1;
                    sched(1'b0, ar, w2, data2);
                    prev_a = ar;
                    free   = ar + 4 + w2;
                end
            end
        end

        // Directed: reset asserted during write T3 aborts the cycle at once.
        a    = free + 2;
        data = 8'($urandom);
        d_wr[a]    = 1'b1;
        d_wdata[a] = data;
        sched(1'b1, a, 0, data);
        r = a + 3;
        for (int k = r; k < r + 3; k++) d_rst[k] = 1'b1;
        for (int k = r; k < NCYC; k++) begin
            e_acc[k]   = 1'b0;
            e_busy[k]  = 1'b0;
            e_dout[k]  = 1'b0;
            e_nrd[k]   = 1'b1;
            e_nwr[k]   = 1'b1;
            e_rdv[k]   = 1'b0;
            e_dv[k]    = 8'h00;
            e_rdata[k] = 8'h00;
        end
        end_cyc = r + 15;

        nRESET = 1'b0;
        WR_REQ = 1'b0;
        RD_REQ = 1'b0;
        WAIT   = 1'b0;
        WDATA  = 8'h00;
        DL     = 8'h00;
        for (int k = 0; k < end_cyc; k++) begin
            @(posedge CLK);
            #1;
            nRESET = !d_rst[k];
            WR_REQ = d_wr[k];
            RD_REQ = d_rd[k];
            WAIT   = d_wait[k];
            WDATA  = d_wdata[k];
            DL     = d_dl[k];
        end
    end

    // Monitor: per-cycle output comparison plus data scoreboard pops.
    initial begin
        logic       dout_prev;
        logic [7:0] exp;
        dout_prev = 1'b0;
        for (int k = 0; k < NCYC; k++) begin
            @(negedge CLK);
            if (k >= end_cyc) break;
            check("ACCEPT",   k, 32'(ACCEPT),   32'(e_acc[k]));
            check("BUSY",     k, 32'(BUSY),     32'(e_busy[k]));
            check("DataOut",  k, 32'(DataOut),  32'(e_dout[k]));
            check("nRD",      k, 32'(nRD),      32'(e_nrd[k]));
            check("nWR",      k, 32'(nWR),      32'(e_nwr[k]));
            check("RD_VALID", k, 32'(RD_VALID), 32'(e_rdv[k]));
            check("DV",       k, 32'(DV),       32'(e_dv[k]));
            check("RDATA",    k, 32'(RDATA),    32'(e_rdata[k]));
            if (DataOut === 1'b1 && dout_prev !== 1'b1) begin
                if (wr_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL wr_scoreboard cycle %0d: DataOut rose, got DV %0h expected none",
                             k, DV);
                end else begin
                    exp = wr_q.pop_front();
                    check("DV_on_drive", k, 32'(DV), 32'(exp));
                end
            end
            if (RD_VALID === 1'b1) begin
                if (rd_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rd_scoreboard cycle %0d: RD_VALID, got RDATA %0h expected none",
                             k, RDATA);
                end else begin
                    exp = rd_q.pop_front();
                    check("RDATA_on_valid", k, 32'(RDATA), 32'(exp));
                end
            end
            dout_prev = DataOut;
        end
        check("wr_left", end_cyc, 32'(wr_q.size()), 32'd0);
        check("rd_left", end_cyc, 32'(rd_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
